ov7670_config_seq: RTL and testbench

Sequencer that walks the OV7670 configuration ROM and writes each {register, value} entry to the camera over the SCCB write master.
- Interprets the ROM sentinels: 16'hFFFF = end of table, 16'hFFF0 = timed delay.
- Retries NACKed writes and reports completion and error status to the top-level camera bring-up logic.
- Sits between the config ROM and the SCCB master, ahead of the capture path.

---
 rtl/ov7670_config_seq_pkg.sv | 31 +++
 rtl/ov7670_config_seq_if.sv | 30 +++
 rtl/ov7670_config_seq_cfg_delay_timer.sv | 40 ++++
 rtl/ov7670_config_seq.sv | 147 ++++++++++++++
 tb/tb_ov7670_config_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_config_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_pkg                                                                 |
// | Shared types and constants for the OV7670 configuration sequencer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ov7670_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WAIT_ROM  = 4'd2,
    ST_DECODE    = 4'd3,
    ST_SEND      = 4'd4,
    ST_WAIT_SCCB = 4'd5,
    ST_DELAY     = 4'd6,
    ST_ADVANCE   = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  localparam logic [15:0] ROM_END        = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY      = 16'hFFF0;
  localparam logic [7:0]  OV7670_SCCB_ID = 8'h42;

  function automatic int unsigned delay_cycles(input int unsigned clk_hz,
                                               input int unsigned delay_ms);
    return (clk_hz / 1000) * delay_ms;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_config_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_config_seq_if                                                       |
// | Config ROM read port and SCCB write-request bus of the sequencer.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ov7670_config_seq_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [15:0]       rom_data;
  logic              sccb_req;
  logic [7:0]        sccb_reg;
  logic [7:0]        sccb_val;
  logic              sccb_ready;
  logic              sccb_done;
  logic              sccb_nack;

  modport master (
    output rom_addr, rom_en, sccb_req, sccb_reg, sccb_val,
    input  rom_data, sccb_ready, sccb_done, sccb_nack
  );

  modport slave (
    input  rom_addr, rom_en, sccb_req, sccb_reg, sccb_val,
    output rom_data, sccb_ready, sccb_done, sccb_nack
  );
endinterface
`default_nettype wire

// File: rtl/ov7670_config_seq_cfg_delay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfg_delay_timer                                                            |
// | Loadable down-counter; expired is high while enabled and at zero.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cfg_delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ov7670_config_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ov7670_config_seq                                                          |
// | Walks the OV7670 config ROM and issues each entry as an SCCB write.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ov7670_config_seq
  import ov7670_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DELAY_MS  = 10,
  parameter int MAX_RETRY = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  ov7670_config_seq_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned DELAY_CYCLES = delay_cycles(CLK_HZ, DELAY_MS);
  localparam int DLY_W   = (DELAY_CYCLES == 0) ? 1 : $clog2(DELAY_CYCLES + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [DLY_W-1:0]   DELAY_LOAD = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         val_q, val_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               err_q, err_d;
  logic               tmr_load, tmr_en, tmr_expired;

  cfg_delay_timer #(
    .WIDTH (DLY_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (DELAY_LOAD),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    reg_d      = reg_q;
    val_d      = val_q;
    retry_d    = retry_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_FETCH;
          rom_addr_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_WAIT_ROM;
      ST_WAIT_ROM: begin
        // The only place the outgoing register/value pair is updated.
        reg_d   = bus.rom_data[15:8];
        val_d   = bus.rom_data[7:0];
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if ({reg_q, val_q} == ROM_END) begin
          state_d = ST_DONE;
        end else if ({reg_q, val_q} == ROM_DELAY) begin
          tmr_load = 1'b1;
          state_d  = ST_DELAY;
        end else begin
          retry_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.sccb_ready) state_d = ST_WAIT_SCCB;
      end
      ST_WAIT_SCCB: begin
        if (bus.sccb_done) begin
          if (!bus.sccb_nack) begin
            state_d = ST_ADVANCE;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_SEND;
          end else begin
            // Exhausted retries: flag it but keep configuring the rest.
            err_d   = 1'b1;
            state_d = ST_ADVANCE;
          end
        end
      end
      ST_DELAY: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      reg_q      <= '0;
      val_q      <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_en   = (state_q == ST_FETCH);
  assign bus.sccb_req = (state_q == ST_SEND);
  assign bus.sccb_reg = reg_q;
  assign bus.sccb_val = val_q;
  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_config_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ov7670_config_seq                                                       |
// | Randomised bench with ROM/SCCB models and a table-level reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ov7670_config_seq;
  import ov7670_pkg::*;

  localparam int CLK_HZ       = 1000;
  localparam int DELAY_MS     = 5;
  localparam int MAX_RETRY    = 3;
  localparam int ADDR_W       = 8;
  localparam int DELAY_CYCLES = CLK_HZ / 1000 * DELAY_MS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  ov7670_config_seq_if #(.ADDR_W(ADDR_W)) bus ();

  ov7670_config_seq #(
    .CLK_HZ    (CLK_HZ),
    .DELAY_MS  (DELAY_MS),
    .MAX_RETRY (MAX_RETRY),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  int          lat = 1;
  bit          stall = 1'b0;
  bit          plan_q[$];
  bit          model_plan[$];
  logic [15:0] wr_q[$];
  int          done_cyc_q[$];
  int          req_rise_q[$];
  int          cyc = 0;
  logic        req_prev = 1'b0;
  bit          inflight = 1'b0;
  int          lat_cnt = 0;
  bit          cur_nack = 1'b0;

  logic [15:0] exp_q[$];
  logic        exp_err;
  int          exp_addr;

  int n_chk = 0;
  int n_err = 0;

  // ROM: data for the address presented with rom_en appears next cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  // SCCB master: idle => ready; done pulse lat cycles after acceptance
  assign bus.sccb_ready = !inflight && !stall;

  always @(posedge clk) begin
    bus.sccb_done <= 1'b0;
    bus.sccb_nack <= 1'b0;
    if (inflight) begin
      if (lat_cnt <= 1) begin
        bus.sccb_done <= 1'b1;
        bus.sccb_nack <= cur_nack;
        inflight      <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (bus.sccb_req && bus.sccb_ready) begin
      wr_q.push_back({bus.sccb_reg, bus.sccb_val});
      inflight <= 1'b1;
      lat_cnt  <= lat;
      if (plan_q.size() > 0) cur_nack <= plan_q.pop_front();
      else                   cur_nack <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.sccb_done) done_cyc_q.push_back(cyc);
    if (bus.sccb_req && !req_prev) req_rise_q.push_back(cyc);
    req_prev <= bus.sccb_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic rom_clear();
    foreach (rom[i]) rom[i] = ROM_END;
  endtask

  // Walk the table as the camera sees it: each real entry is tried up to
  // MAX_RETRY+1 times, consuming the NACK plan one accepted write at a time.
  task automatic model_run();
    int  p = 0;
    bit  ok;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_addr = 255;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == ROM_END) begin
        exp_addr = a;
        break;
      end
      if (rom[a] == ROM_DELAY) continue;
      ok = 1'b0;
      for (int t = 0; t <= MAX_RETRY && !ok; t++) begin
        exp_q.push_back(rom[a]);
        ok = (p < model_plan.size()) ? !model_plan[p] : 1'b1;
        p++;
      end
      if (!ok) exp_err = 1'b1;
    end
  endtask

  task automatic run_case(input bit mid_start, input int stall_cyc);
    model_plan = plan_q;
    model_run();
    wr_q.delete();
    done_cyc_q.delete();
    req_rise_q.delete();
    stall = (stall_cyc > 0);
    pulse_start();
    if (mid_start) begin
      wait_cycles(5);
      chk("busy_mid", busy, 1);
      pulse_start();
    end
    if (stall_cyc > 0) begin
      wait_cycles(10);
      chk("stall_req_early", bus.sccb_req, 1);
      wait_cycles(stall_cyc - 10);
      chk("stall_req", bus.sccb_req, 1);
      chk("stall_regval", {bus.sccb_reg, bus.sccb_val}, exp_q[0]);
      chk("stall_accepts", wr_q.size(), 0);
      chk("stall_addr", bus.rom_addr, 0);
      stall = 1'b0;
    end
    wait_done(20000);
    chk("n_writes", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("write%0d", i), wr_q[i], exp_q[i]);
    chk("err", err, exp_err);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("rom_addr_end", bus.rom_addr, exp_addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rom_clear();
    wait_cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_req", bus.sccb_req, 0);
    chk("rst_regval", {bus.sccb_reg, bus.sccb_val}, 0);
    rst_n = 1'b1;
    wait_cycles(2);
    chk("idle_busy", busy, 0);

    // Two writes, with a start pulse mid-sequence that must be ignored
    rom_clear();
    rom[0] = 16'h1280; rom[1] = 16'h1100;
    lat = 20;
    run_case(1'b1, 0);

    // Timed delay entry between two writes
    rom_clear();
    rom[0] = 16'h1280; rom[1] = ROM_DELAY; rom[2] = 16'h1204;
    lat = 3;
    run_case(1'b0, 0);
    chk("dly_req_rises", req_rise_q.size(), 2);
    // done seen; ADVANCE,FETCH,WAIT_ROM,DECODE; delay; same four again; SEND
    if (req_rise_q.size() >= 2 && done_cyc_q.size() >= 1)
      chk("dly_gap", req_rise_q[1] - done_cyc_q[0], 4 + DELAY_CYCLES + 4 + 1);

    // Two NACKs then ACK
    rom_clear();
    rom[0] = 16'h1280;
    plan_q = '{1'b1, 1'b1, 1'b0};
    lat = 4;
    run_case(1'b0, 0);

    // NACK on every attempt of entry 0, entry 1 still written
    rom_clear();
    rom[0] = 16'h1280; rom[1] = 16'h1100;
    plan_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_case(1'b0, 0);

    // Master not ready for 50 cycles
    rom_clear();
    rom[0] = 16'h1280;
    plan_q.delete();
    lat = 2;
    run_case(1'b0, 50);

    // No end marker: stop at the last address, no wrap
    foreach (rom[i]) rom[i] = 16'h3A04;
    lat = 1;
    run_case(1'b0, 0);

    // Reset while the SCCB write is outstanding; its done must be ignored
    rom_clear();
    rom[0] = 16'h1280;
    lat = 20;
    wr_q.delete();
    pulse_start();
    n = 0;
    while (wr_q.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_accept", wr_q.size(), 1);
    wait_cycles(3);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_req", bus.sccb_req, 0);
    chk("rstmid_regval", {bus.sccb_reg, bus.sccb_val}, 0);
    chk("rstmid_addr", bus.rom_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_cycles(40);
    chk("stray_busy", busy, 0);
    chk("stray_done", done, 0);
    chk("stray_accepts", wr_q.size(), 1);

    // Randomised tables, NACK patterns and latencies
    for (int k = 0; k < 20; k++) begin
      rom_clear();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) rom[i] = ROM_DELAY;
        else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      end
      plan_q.delete();
      for (int i = 0; i < 30; i++) plan_q.push_back($urandom_range(0, 3) == 0);
      lat = $urandom_range(1, 6);
      run_case(1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
